// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the fetch handshake and the external adder loop of the PC sequencer.
//   pc, pc_valid   : address offered to instruction fetch (sequencer -> fetch)
//   ready          : fetch accepts pc this cycle          (fetch -> sequencer)
//   add_a, add_b   : adder operands                        (sequencer -> adder)
//   sum_in         : (add_a + add_b) mod 2^WIDTH            (adder -> sequencer)
// Modport master is the sequencer side, slave the fetch/adder side.
interface pc_sequencer_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             ready;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum_in;

  modport master (
    output pc,
    output pc_valid,
    output add_a,
    output add_b,
    input  ready,
    input  sum_in
  );

  modport slave (
    input  pc,
    input  pc_valid,
    input  add_a,
    input  add_b,
    output ready,
    output sum_in
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter register stage closing the PC increment loop through an
// external combinational adder. Offers the PC to fetch with valid/ready,
// supports redirect loads, halt, stall, a rollover pulse and a saturating
// count of accepted fetch addresses.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_en         start request, IDLE -> RUN
//   i_halt       stop request (RUN only)
//   i_load       redirect strobe
//   i_load_addr  redirect target
//   o_wrapped    one-cycle pulse after an advance that rolled over
//   o_state      00 IDLE, 01 RUN, 10 HALTED
//   o_acc_cnt    saturating count of accepted handshakes
//   bus          fetch handshake + adder operands/result (master side)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | pc held, not offered; load rewrites pc; en starts offering
// RUN     | pc offered (pc_valid=1); halt > load > advance on each edge
// HALTED  | pc held, not offered; only load (resume) or reset leaves
module pc_sequencer #(
  parameter int WIDTH      = 6,
  parameter int STEP       = 1,
  parameter int RESET_ADDR = 0,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_halt,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_addr,
  output logic             o_wrapped,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_acc_cnt,
  pc_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic             r_wrapped;
  logic [CNT_W-1:0] r_acc_cnt;

  logic             w_pc_valid;
  logic             w_accept;
  logic             w_advance;
  logic             w_load_take;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_halt) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (i_load) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_pc_valid  = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_load_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load_take = i_load;
      end
      ST_RUN: begin
        w_pc_valid  = 1'b1;
        // A handshake is counted even on a halting or redirecting edge:
        // fetch did take the address that was on the bus.
        w_accept    = bus.ready;
        w_load_take = i_load & ~i_halt;
        w_advance   = bus.ready & ~i_halt & ~i_load;
      end
      ST_HALTED: begin
        w_load_take = i_load;
      end
      default: begin
        w_pc_valid = 1'b0;
      end
    endcase
  end

  // PC, rollover pulse and accept counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc      <= RESET_V;
      r_wrapped <= 1'b0;
      r_acc_cnt <= '0;
    end else begin
      // With a nonzero step, the modular sum only drops below pc on rollover.
      r_wrapped <= w_advance & (bus.sum_in < r_pc);
      if (w_load_take) begin
        r_pc <= i_load_addr;
      end else if (w_advance) begin
        r_pc <= bus.sum_in;
      end
      if (w_accept && (r_acc_cnt != CNT_MAX)) begin
        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_valid = w_pc_valid;
  assign bus.add_a    = r_pc;
  assign bus.add_b    = STEP_V;

  assign o_wrapped = r_wrapped;
  assign o_state   = r_state;
  assign o_acc_cnt = r_acc_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-width instance for the main
// sequences, and a CNT_W=3 instance for counter saturation. The bench plays
// the role of the external adder on each interface.
module tb_pc_sequencer;

  logic clk;
  int   n_vec;
  int   n_err;

  // Main instance (defaults)
  logic       rst, en, halt, load, ready;
  logic [5:0] load_addr;
  logic       wrapped;
  logic [1:0] state;
  logic [7:0] acc_cnt;

  // Saturation instance (CNT_W=3)
  logic       rst_s, en_s, halt_s, load_s, ready_s;
  logic [5:0] load_addr_s;
  logic       wrapped_s;
  logic [1:0] state_s;
  logic [2:0] acc_cnt_s;

  pc_sequencer_if #(.WIDTH(6)) bus_a ();
  pc_sequencer_if #(.WIDTH(6)) bus_s ();

  assign bus_a.ready  = ready;
  assign bus_a.sum_in = bus_a.add_a + bus_a.add_b;
  assign bus_s.ready  = ready_s;
  assign bus_s.sum_in = bus_s.add_a + bus_s.add_b;

  pc_sequencer #(.WIDTH(6), .STEP(1), .RESET_ADDR(0), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_halt      (halt),
    .i_load      (load),
    .i_load_addr (load_addr),
    .o_wrapped   (wrapped),
    .o_state     (state),
    .o_acc_cnt   (acc_cnt),
    .bus         (bus_a)
  );

  pc_sequencer #(.WIDTH(6), .STEP(1), .RESET_ADDR(0), .CNT_W(3)) dut_sat (
    .i_clk       (clk),
    .i_rst       (rst_s),
    .i_en        (en_s),
    .i_halt      (halt_s),
    .i_load      (load_s),
    .i_load_addr (load_addr_s),
    .o_wrapped   (wrapped_s),
    .o_state     (state_s),
    .o_acc_cnt   (acc_cnt_s),
    .bus         (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the commonly observed outputs of the main instance.
  task automatic chk_main(input string tag, input int e_pc, input int e_state,
                          input int e_valid, input int e_wrap, input int e_acc);
    chk({tag, ".pc"},       32'(bus_a.pc),       32'(e_pc));
    chk({tag, ".state"},    32'(state),          32'(e_state));
    chk({tag, ".pc_valid"}, 32'(bus_a.pc_valid), 32'(e_valid));
    chk({tag, ".wrapped"},  32'(wrapped),        32'(e_wrap));
    chk({tag, ".acc_cnt"},  32'(acc_cnt),        32'(e_acc));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b1; halt = 1'b0; load = 1'b1; load_addr = 6'd33; ready = 1'b1;
    rst_s = 1'b1; en_s = 1'b0; halt_s = 1'b0; load_s = 1'b0; load_addr_s = 6'd0; ready_s = 1'b0;

    // Reset held two cycles with other inputs active
    step();
    step();
    chk_main("reset", 0, 0, 0, 0, 0);
    chk("reset.add_b", 32'(bus_a.add_b), 32'd1);

    // Start: first offered pc is the current pc, no increment
    rst = 1'b0; load = 1'b0; en = 1'b1; ready = 1'b1;
    step();
    chk_main("start", 0, 1, 1, 0, 0);
    chk("start.add_a", 32'(bus_a.add_a), 32'd0);
    en = 1'b0;
    step(); chk_main("run1", 1, 1, 1, 0, 1);
    step(); chk_main("run2", 2, 1, 1, 0, 2);
    step(); chk_main("run3", 3, 1, 1, 0, 3);
    step(); chk_main("run4", 4, 1, 1, 0, 4);
    step(); chk_main("run5", 5, 1, 1, 0, 5);

    // Stall at pc=5
    ready = 1'b0;
    step(); chk_main("stall1", 5, 1, 1, 0, 5);
    step(); chk_main("stall2", 5, 1, 1, 0, 5);
    step(); chk_main("stall3", 5, 1, 1, 0, 5);
    ready = 1'b1;
    step(); chk_main("unstall", 6, 1, 1, 0, 6);
    step(); step(); step(); step();
    chk_main("pc10", 10, 1, 1, 0, 10);

    // Redirect while stalled
    load = 1'b1; load_addr = 6'd40; ready = 1'b0;
    step(); chk_main("redir40", 40, 1, 1, 0, 10);

    // Halt beats load; handshake on this edge still counted
    halt = 1'b1; load = 1'b1; load_addr = 6'd33; ready = 1'b1;
    step(); chk_main("halt", 40, 2, 0, 0, 11);

    // HALTED ignores en and ready
    halt = 1'b0; load = 1'b0; en = 1'b1; ready = 1'b1;
    step(); chk_main("halted_hold", 40, 2, 0, 0, 11);

    // Resume at redirect
    en = 1'b0; load = 1'b1; load_addr = 6'd7; ready = 1'b0;
    step(); chk_main("resume7", 7, 1, 1, 0, 11);

    // Reset mid-run with a pending load
    load = 1'b1; load_addr = 6'd20;
    step(); chk_main("pc20", 20, 1, 1, 0, 11);
    rst = 1'b1; load = 1'b1; load_addr = 6'd50; ready = 1'b1;
    step(); chk_main("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0; load = 1'b0; ready = 1'b0;

    // Load in IDLE stays IDLE
    load = 1'b1; load_addr = 6'd62;
    step(); chk_main("idle_load", 62, 0, 0, 0, 0);
    load = 1'b0;
    step(); chk_main("idle_hold", 62, 0, 0, 0, 0);

    // Wrap 62,63,0,1
    en = 1'b1; ready = 1'b1;
    step(); chk_main("wrap62", 62, 1, 1, 0, 0);
    en = 1'b0;
    step(); chk_main("wrap63", 63, 1, 1, 0, 1);
    step(); chk_main("wrap0",  0,  1, 1, 1, 2);
    step(); chk_main("wrap1",  1,  1, 1, 0, 3);

    // Load to a lower address is not a rollover
    load = 1'b1; load_addr = 6'd0; ready = 1'b0;
    step(); chk_main("load_down", 0, 1, 1, 0, 3);
    load = 1'b0;

    // Saturation on a 3-bit counter
    rst_s = 1'b0; en_s = 1'b1; ready_s = 1'b1;
    step();
    chk("sat.state", 32'(state_s), 32'd1);
    chk("sat.acc0", 32'(acc_cnt_s), 32'd0);
    en_s = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("sat.acc%0d", k), 32'(acc_cnt_s), (k < 7) ? 32'(k) : 32'd7);
    end
    chk("sat.pc", 32'(bus_s.pc), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
